// File: rtl/doa_scan_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : doa_scan_ctrl
//  Purpose  : Direction-of-arrival sweep sequencer; drives the steering LUT and
//             the abs_sq_cmul/ma datapath, and reports the strongest direction.
//  Revision : 1.0 - initial release
// ============================================================================
module doa_scan_ctrl #(
    parameter int WORD_LENGTH     = 16,
    parameter int WORD_LENGTH_OUT = (WORD_LENGTH * 2 + 3) * 2 + 1,
    parameter int N_ANGLES        = 181,
    parameter int N_AVG           = 64,
    parameter int MA_LATENCY      = 2,
    parameter int ADDR_W          = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic                       abort,
    output logic                       busy,
    output logic                       done,
    input  logic                       smp_valid,
    output logic                       smp_ready,
    output logic [ADDR_W-1:0]          steer_addr,
    output logic                       ma_rst,
    output logic                       ma_en,
    input  logic [WORD_LENGTH_OUT-1:0] ma_out,
    output logic                       scan_valid,
    output logic [ADDR_W-1:0]          scan_idx,
    output logic [WORD_LENGTH_OUT-1:0] scan_pow,
    output logic [ADDR_W-1:0]          peak_idx,
    output logic [WORD_LENGTH_OUT-1:0] peak_pow
);

    // The shared counter serves both the sample count and the drain wait.
    localparam int CNT_MAX    = (N_AVG > MA_LATENCY) ? N_AVG : MA_LATENCY;
    localparam int CNT_W      = $clog2(CNT_MAX + 1);
    localparam int DRAIN_LAST = (MA_LATENCY > 0) ? MA_LATENCY - 1 : 0;

    localparam logic [ADDR_W-1:0] LAST_ANGLE = ADDR_W'(N_ANGLES - 1);
    localparam logic [CNT_W-1:0]  LAST_SMP   = CNT_W'(N_AVG - 1);
    localparam logic [CNT_W-1:0]  LAST_DRAIN = CNT_W'(DRAIN_LAST);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_CLEAR = 3'd1,
        S_LOAD  = 3'd2,
        S_ACCUM = 3'd3,
        S_DRAIN = 3'd4,
        S_EVAL  = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    state_t                     r_state;
    logic [ADDR_W-1:0]          r_angle;
    logic [CNT_W-1:0]           r_count;
    logic                       r_busy;
    logic                       r_done;
    logic                       r_smp_ready;
    logic                       r_ma_rst;
    logic                       r_scan_valid;
    logic [ADDR_W-1:0]          r_scan_idx;
    logic [WORD_LENGTH_OUT-1:0] r_scan_pow;
    logic [ADDR_W-1:0]          r_peak_idx;
    logic [WORD_LENGTH_OUT-1:0] r_peak_pow;
    logic                       r_max_vld;
    logic [ADDR_W-1:0]          r_max_idx;
    logic [WORD_LENGTH_OUT-1:0] r_max_pow;

    // Strict compare keeps the earlier (lower) index on ties.
    logic                       w_take;
    logic [ADDR_W-1:0]          w_max_idx;
    logic [WORD_LENGTH_OUT-1:0] w_max_pow;

    assign w_take    = !r_max_vld || (ma_out > r_max_pow);
    assign w_max_idx = w_take ? r_angle : r_max_idx;
    assign w_max_pow = w_take ? ma_out  : r_max_pow;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_angle      <= '0;
            r_count      <= '0;
            r_busy       <= 1'b0;
            r_done       <= 1'b0;
            r_smp_ready  <= 1'b0;
            r_ma_rst     <= 1'b0;
            r_scan_valid <= 1'b0;
            r_scan_idx   <= '0;
            r_scan_pow   <= '0;
            r_peak_idx   <= '0;
            r_peak_pow   <= '0;
            r_max_vld    <= 1'b0;
            r_max_idx    <= '0;
            r_max_pow    <= '0;
        end else begin
            r_ma_rst     <= 1'b0;
            r_done       <= 1'b0;
            r_scan_valid <= 1'b0;
            if (abort && (r_state != S_IDLE)) begin
                r_state     <= S_IDLE;
                r_busy      <= 1'b0;
                r_smp_ready <= 1'b0;
                r_ma_rst    <= 1'b1;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        r_max_vld <= 1'b0;
                        r_max_idx <= '0;
                        r_max_pow <= '0;
                        if (start && !abort) begin
                            r_state  <= S_CLEAR;
                            r_angle  <= '0;
                            r_busy   <= 1'b1;
                            r_ma_rst <= 1'b1;
                        end
                    end
                    S_CLEAR: r_state <= S_LOAD;
                    S_LOAD: begin
                        r_state     <= S_ACCUM;
                        r_count     <= '0;
                        r_smp_ready <= 1'b1;
                    end
                    S_ACCUM: begin
                        if (smp_valid) begin
                            if (r_count == LAST_SMP) begin
                                r_count     <= '0;
                                r_smp_ready <= 1'b0;
                                r_state     <= (MA_LATENCY == 0) ? S_EVAL : S_DRAIN;
                            end else begin
                                r_count <= r_count + 1'b1;
                            end
                        end
                    end
                    S_DRAIN: begin
                        if (r_count == LAST_DRAIN) begin
                            r_count <= '0;
                            r_state <= S_EVAL;
                        end else begin
                            r_count <= r_count + 1'b1;
                        end
                    end
                    S_EVAL: begin
                        r_scan_pow   <= ma_out;
                        r_scan_idx   <= r_angle;
                        r_scan_valid <= 1'b1;
                        r_max_vld    <= 1'b1;
                        r_max_idx    <= w_max_idx;
                        r_max_pow    <= w_max_pow;
                        // Peak is loaded here so it appears alongside the done pulse.
                        if (r_angle == LAST_ANGLE) begin
                            r_state    <= S_DONE;
                            r_done     <= 1'b1;
                            r_peak_idx <= w_max_idx;
                            r_peak_pow <= w_max_pow;
                        end else begin
                            r_angle  <= r_angle + 1'b1;
                            r_state  <= S_CLEAR;
                            r_ma_rst <= 1'b1;
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state     <= S_IDLE;
                        r_busy      <= 1'b0;
                        r_smp_ready <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign busy       = r_busy;
    assign done       = r_done;
    assign smp_ready  = r_smp_ready;
    assign ma_en      = smp_valid & r_smp_ready;
    assign ma_rst     = r_ma_rst;
    assign steer_addr = r_angle;
    assign scan_valid = r_scan_valid;
    assign scan_idx   = r_scan_idx;
    assign scan_pow   = r_scan_pow;
    assign peak_idx   = r_peak_idx;
    assign peak_pow   = r_peak_pow;

endmodule
`default_nettype wire

// File: doc/doa_scan_ctrl.md
# doa_scan_ctrl

Sequencer for the beamforming power datapath (4-channel steering-vector complex multiply with squared magnitude, followed by the moving average). It sweeps the steering-vector index over `N_ANGLES` look directions. For each direction it clears the moving average, feeds it `N_AVG` handshaken samples, and captures the averaged power. When the sweep ends it publishes the index and power of the strongest direction. It sits between the sample source and the steering LUT on one side and the `abs_sq_cmul`/`ma` pair on the other.

## Interface
- `WORD_LENGTH`, 16, sample/steering component width (informational, sets `WORD_LENGTH_OUT`)
- `WORD_LENGTH_OUT`, (WORD_LENGTH*2+3)*2+1 = 71, width of the `ma` output power word
- `N_ANGLES`, 181, number of steering vectors per sweep (≥1)
- `N_AVG`, 64, samples accumulated per direction (≥1)
- `MA_LATENCY`, 2, cycles from last `ma_en` to valid `ma_out` (≥0)
- `ADDR_W`, 8, steering LUT address width; must hold `N_ANGLES-1`

Ports:
- `clk` in 1: single clock, rising edge
- `rst` in 1: synchronous, active-high reset
- `start` in 1: begin a sweep; sampled only in IDLE
- `abort` in 1: cancel the sweep in progress
- `busy` out 1: high in every state except IDLE
- `done` out 1: one-cycle pulse when a sweep completes
- `smp_valid` in 1: the sample source presents a sample
- `smp_ready` out 1: the controller accepts a sample
- `steer_addr` out ADDR_W: steering LUT address (LUT read latency is 1 cycle)
- `ma_rst` out 1: clear for `ma`
- `ma_en` out 1: advance for `ma`
- `ma_out` in WORD_LENGTH_OUT: averaged power, unsigned
- `scan_valid` out 1: one-cycle pulse per evaluated direction
- `scan_idx` out ADDR_W: direction of the current `scan_pow`
- `scan_pow` out WORD_LENGTH_OUT: captured power for `scan_idx`
- `peak_idx` out ADDR_W: strongest direction of the last completed sweep
- `peak_pow` out WORD_LENGTH_OUT: power at `peak_idx`

## Operation
- FSM states: IDLE, CLEAR, LOAD, ACCUM, DRAIN, EVAL, DONE.
- **IDLE**
  - `start`=1 → CLEAR with angle=0.
  - Working max is cleared to 0 and its valid flag is cleared.
- **CLEAR**
  - `ma_rst`=1 for exactly this cycle; `steer_addr`=angle.
  - Always → LOAD.
- **LOAD**
  - One cycle for LUT data to settle at the `abs_sq_cmul` inputs.
  - Always → ACCUM with sample count=0.
- **ACCUM**
  - `smp_ready`=1.
  - `ma_en` = `smp_valid & smp_ready`, combinational from registered state.
  - The count increments on each handshake.
  - Handshake at count=`N_AVG-1` → DRAIN.
- **DRAIN**
  - Waits `MA_LATENCY` cycles; 0 means it exits immediately → EVAL.
- **EVAL**
  - Registers `ma_out` into `scan_pow` and angle into `scan_idx`; pulses `scan_valid`.
  - Updates the working max when the flag is clear or `ma_out` is strictly greater than the working max (unsigned). Ties keep the lower index.
  - If angle=`N_ANGLES-1` → DONE; else angle+1 → CLEAR.
- **DONE**
  - Copies the working max and its index into `peak_pow`/`peak_idx`; pulses `done`.
  - → IDLE.
- `steer_addr` holds the current angle in every non-IDLE state and holds its last value in IDLE.
- `start` while busy is ignored.
- **abort**
  - Has priority over all transitions except `rst`.
  - In any non-IDLE state → IDLE next cycle, with `ma_rst`=1 in that cycle.
  - No `done` or `scan_valid` pulse; `peak_*` keeps the last completed sweep's values.
- `abort` together with `start` in IDLE: `abort` wins and the FSM stays in IDLE.
- Stalls: `smp_valid`=0 in ACCUM holds the count and `ma_en`=0; there is no timeout.

## Timing
- Reset values: every output is 0, state=IDLE, angle=0, count=0.
- `rst` mid-sweep returns to IDLE in the next cycle and clears `peak_*` to 0.
- `busy` goes high the cycle after `start` is sampled.
- Per-direction cycles with `smp_valid` held high: 1 (CLEAR) + 1 (LOAD) + `N_AVG` + `MA_LATENCY` + 1 (EVAL) = `N_AVG+MA_LATENCY+3`.
- Full sweep from the `start` cycle to the `done` pulse: `N_ANGLES*(N_AVG+MA_LATENCY+3)+1` cycles.
- `busy` drops the cycle after `done`.
- `peak_*` updates in the same cycle `done` is asserted and is stable until the next `done` or `rst`.
- Exactly `N_AVG` `ma_en` pulses occur per direction, all strictly after the `ma_rst` pulse.

## Test plan
- Nominal, with `N_ANGLES`=4, `N_AVG`=4, `MA_LATENCY`=2, `smp_valid`=1 and `ma_out` modelled as the powers 10, 40, 25, 5 per angle:
  - 4 `scan_valid` pulses, 9 cycles apart, with `scan_idx` 0..3.
  - `done` at cycle 37 after `start`; `peak_idx`=1, `peak_pow`=40.
- Tie, with powers 7, 7, 3, 7 → `peak_idx`=0, `peak_pow`=7.
- Backpressure: `smp_valid` toggles 1,0,1,0 during ACCUM:
  - exactly 4 `ma_en` pulses per angle;
  - the sweep length is extended by exactly the number of invalid cycles.
- Abort: assert `abort` during ACCUM of angle 2 after a prior sweep that produced peak (1,40):
  - next cycle is IDLE with `ma_rst`=1;
  - no `done`; `peak_idx`/`peak_pow` still 1/40.
- `rst` during DRAIN of angle 3:
  - next cycle has all outputs 0 and `busy`=0;
  - a new `start` then runs a full 37-cycle sweep.
- `start` pulsed while busy → no effect on sweep length or results; `start`+`abort` in IDLE → `busy` stays 0.
